// File: rtl/vm_pkg.sv
// Shared definitions for the coin button front end.
//   chan_state_e : per-channel debounce FSM state
//   NUM_COINS    : number of coin buttons handled
//   COIN5/10/25  : bit index of each coin in the channel vectors
package vm_pkg;

  typedef enum logic [2:0] {
    LOCKOUT,
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } chan_state_e;

  localparam int NUM_COINS = 3;
  localparam int COIN5     = 0;
  localparam int COIN10    = 1;
  localparam int COIN25    = 2;

endpackage

// File: rtl/debounce_channel.sv
// One coin button channel: two-flop synchroniser, debounce FSM and its
// stability counter.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   button  : raw asynchronous, bouncy, active-high button
//   level   : registered debounced level
//   accept  : one-cycle strobe, high in the cycle a press is being accepted
//             (coincides with the clock edge that raises level)
module debounce_channel
  import vm_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic level,
  output logic accept
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             meta_p0;
  logic             sync_p1;
  chan_state_e      state;
  logic [CNT_W-1:0] cnt;

  // The strobe is decoded from the current state so that the pending bit in
  // the top is set on the same edge that raises level.
  assign accept = (state == PRESS_WAIT) && sync_p1 && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      state   <= LOCKOUT;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // Stage p0 -> p1: synchroniser; only sync_p1 is used below
      meta_p0 <= button;
      sync_p1 <= meta_p0;

      // Debounce FSM on the synchronised sample. The counter only advances
      // below CNT_LAST, so it can never wrap.
      case (state)
        LOCKOUT: begin
          // A button held through reset must be seen stably released first.
          if (sync_p1) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (sync_p1) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_p1) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            level <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync_p1) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync_p1) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            level <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOCKOUT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/coin_button_conditioner.sv
// Front end between the three raw coin buttons and the vending FSM.
// Each button is synchronised and debounced; every accepted press is
// queued in a pending register and emitted as a single-cycle edge pulse,
// at most one per cycle, in priority order 25c > 10c > 5c.
// Ports:
//   clk           : system clock
//   reset_n       : asynchronous active-low reset
//   button_1/2/3  : raw 5/10/25-cent buttons (asynchronous, active-high)
//   button_1/2/3_edge : registered one-cycle pulse per accepted press
//   button_level  : debounced levels {b3,b2,b1}
module coin_button_conditioner
  import vm_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       button_1,
  input  logic       button_2,
  input  logic       button_3,
  output logic       button_1_edge,
  output logic       button_2_edge,
  output logic       button_3_edge,
  output logic [2:0] button_level
);

  logic [NUM_COINS-1:0] raw;
  logic [NUM_COINS-1:0] level;
  logic [NUM_COINS-1:0] accept;
  logic [NUM_COINS-1:0] pending_p0;
  logic [NUM_COINS-1:0] grant;
  logic [NUM_COINS-1:0] edge_p1;

  assign raw[COIN5]  = button_1;
  assign raw[COIN10] = button_2;
  assign raw[COIN25] = button_3;

  for (genvar k = 0; k < NUM_COINS; k++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .button (raw[k]),
      .level  (level[k]),
      .accept (accept[k])
    );
  end

  // Fixed-priority pick of one pending coin per cycle.
  always_comb begin
    grant = '0;
    if (pending_p0[COIN25]) begin
      grant[COIN25] = 1'b1;
    end else if (pending_p0[COIN10]) begin
      grant[COIN10] = 1'b1;
    end else if (pending_p0[COIN5]) begin
      grant[COIN5] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_p0 <= '0;
      edge_p1    <= '0;
    end else begin
      // Stage p0: pending register; a new accept overrides a same-cycle grant
      pending_p0 <= (pending_p0 & ~grant) | accept;
      // Stage p1: registered one-hot edge outputs
      edge_p1    <= grant;
    end
  end

  assign button_1_edge = edge_p1[COIN5];
  assign button_2_edge = edge_p1[COIN10];
  assign button_3_edge = edge_p1[COIN25];
  assign button_level  = level;

endmodule

// File: tb/tb_coin_button_conditioner.sv
module tb_coin_button_conditioner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       button_1 = 1'b0;
  logic       button_2 = 1'b0;
  logic       button_3 = 1'b0;
  logic       button_1_edge;
  logic       button_2_edge;
  logic       button_3_edge;
  logic [2:0] button_level;

  int errors = 0;
  int checks = 0;

  // Edge monitor: totals per channel and count of cycles with >1 edge high.
  int n1 = 0, n2 = 0, n3 = 0, multi = 0;
  int s1, s2, s3;
  int lvl_drop;

  coin_button_conditioner #(
    .STABLE_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button_1     (button_1),
    .button_2     (button_2),
    .button_3     (button_3),
    .button_1_edge(button_1_edge),
    .button_2_edge(button_2_edge),
    .button_3_edge(button_3_edge),
    .button_level (button_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n1 = n1 + int'(button_1_edge);
    n2 = n2 + int'(button_2_edge);
    n3 = n3 + int'(button_3_edge);
    if ((int'(button_1_edge) + int'(button_2_edge) + int'(button_3_edge)) > 1)
      multi = multi + 1;
  end

  function automatic logic [31:0] edges();
    return {29'b0, button_3_edge, button_2_edge, button_1_edge};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s1 = n1; s2 = n2; s3 = n3;
  endtask

  initial begin
    // Reset state
    ticks(3);
    check("reset_edges", edges(), 32'h0);
    check("reset_level", 32'(button_level), 32'h0);
    reset_n = 1'b1;
    ticks(15);
    check("post_reset_edges", edges(), 32'h0);
    check("post_reset_level", 32'(button_level), 32'h0);

    // Clean press on button_1: level at cycle 10, edge at cycle 11
    snap();
    button_1 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 9)  check("b1_level_c9", 32'(button_level), 32'h0);
      if (c == 10) check("b1_level_c10", 32'(button_level), 32'h1);
      if (c == 10) check("b1_edge_c10", edges(), 32'h0);
      if (c == 11) check("b1_edge_c11", edges(), 32'h1);
      if (c == 12) check("b1_edge_c12", edges(), 32'h0);
    end
    check("b1_single_pulse", 32'(n1 - s1), 32'd1);
    button_1 = 1'b0;
    ticks(20);
    check("b1_released_level", 32'(button_level), 32'h0);

    // Bounce on button_2, then held high
    snap();
    for (int b = 0; b < 2; b++) begin
      button_2 = 1'b1;
      ticks(3);
      button_2 = 1'b0;
      ticks(3);
    end
    ticks(4);
    check("b2_bounce_no_edge", 32'(n2 - s2), 32'd0);
    check("b2_bounce_level", 32'(button_level), 32'h0);
    button_2 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 10) check("b2_edge_c10", edges(), 32'h0);
      if (c == 11) check("b2_edge_c11", edges(), 32'h2);
      if (c == 12) check("b2_edge_c12", edges(), 32'h0);
    end
    check("b2_single_pulse", 32'(n2 - s2), 32'd1);
    button_2 = 1'b0;
    ticks(20);

    // Simultaneous press: 25c, 10c, 5c on consecutive cycles
    snap();
    button_1 = 1'b1;
    button_2 = 1'b1;
    button_3 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 10) check("sim_edge_c10", edges(), 32'h0);
      if (c == 10) check("sim_level_c10", 32'(button_level), 32'h7);
      if (c == 11) check("sim_edge_c11", edges(), 32'h4);
      if (c == 12) check("sim_edge_c12", edges(), 32'h2);
      if (c == 13) check("sim_edge_c13", edges(), 32'h1);
      if (c == 14) check("sim_edge_c14", edges(), 32'h0);
    end
    check("sim_counts", 32'((n1 - s1) + (n2 - s2) * 16 + (n3 - s3) * 256), 32'h111);
    button_1 = 1'b0;
    button_2 = 1'b0;
    button_3 = 1'b0;
    ticks(20);

    // button_3 held across reset release: no coin until released and re-pressed
    button_3 = 1'b1;
    ticks(2);
    reset_n = 1'b0;
    ticks(3);
    reset_n = 1'b1;
    snap();
    ticks(30);
    check("held_reset_no_edge", 32'(n3 - s3), 32'd0);
    check("held_reset_level", 32'(button_level), 32'h0);
    button_3 = 1'b0;
    ticks(20);
    check("held_reset_released", 32'(n3 - s3), 32'd0);
    button_3 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 11) check("held_reset_edge_c11", edges(), 32'h4);
    end
    check("held_reset_one_edge", 32'(n3 - s3), 32'd1);
    button_3 = 1'b0;
    ticks(20);

    // Reset while button_2 is pending
    snap();
    button_2 = 1'b1;
    for (int c = 0; c < 11; c++) tick();
    check("midrst_level_before", 32'(button_level), 32'h2);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_async_edges", edges(), 32'h0);
    check("midrst_async_level", 32'(button_level), 32'h0);
    tick();
    check("midrst_edge_in_reset", edges(), 32'h0);
    ticks(2);
    reset_n = 1'b1;
    tick();
    check("midrst_first_cycle", edges(), 32'h0);
    ticks(20);
    check("midrst_no_pulse", 32'(n2 - s2), 32'd0);
    button_2 = 1'b0;
    ticks(20);
    check("midrst_no_pulse_after", 32'(n2 - s2), 32'd0);

    // Release glitch on button_1: level holds, exactly two edges in total
    snap();
    button_1 = 1'b1;
    ticks(15);
    check("glitch_first_edge", 32'(n1 - s1), 32'd1);
    lvl_drop = 0;
    button_1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (button_level[0] !== 1'b1) lvl_drop++;
    end
    button_1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (button_level[0] !== 1'b1) lvl_drop++;
    end
    check("glitch_level_held", 32'(lvl_drop), 32'd0);
    check("glitch_no_retrigger", 32'(n1 - s1), 32'd1);
    button_1 = 1'b0;
    ticks(20);
    check("glitch_release_level", 32'(button_level), 32'h0);
    button_1 = 1'b1;
    ticks(15);
    button_1 = 1'b0;
    ticks(20);
    check("glitch_two_edges", 32'(n1 - s1), 32'd2);

    check("never_two_edges", 32'(multi), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
